// File: rtl/fround_pipe.sv
// Pipelined significand rounder. Stage 1 decides whether to round up; the last stage
// increments, renormalises on carry and saturates on overflow. Valid/ready on both sides.
module fround_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int GRS_W  = 8,
    parameter int STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 sign_i,
    input  logic [MAN_W+GRS_W:0] sig_i,
    input  logic                 sticky_i,
    input  logic [EXP_W-1:0]     exp_i,
    input  logic [2:0]           rm_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 sign_o,
    output logic [MAN_W-1:0]     sig_o,
    output logic [EXP_W-1:0]     exp_o,
    output logic                 nx_o,
    output logic                 of_o
);
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    typedef struct packed {
        logic             sign;
        logic             up;
        logic             nx;
        logic [2:0]       rm;
        logic [MAN_W-1:0] man;
        logic [EXP_W-1:0] exp;
    } dec_t;

    typedef struct packed {
        logic             sign;
        logic [MAN_W-1:0] sig;
        logic [EXP_W-1:0] exp;
        logic             nx;
        logic             of;
    } res_t;

    // The hidden bit is implied by normalisation and never affects the result.
    logic unused_hidden;
    assign unused_hidden = sig_i[MAN_W+GRS_W];

    logic lsb, grd, stk;
    dec_t dec_in;

    always_comb begin
        lsb         = sig_i[GRS_W];
        grd         = sig_i[GRS_W-1];
        stk         = (|sig_i[GRS_W-2:0]) | sticky_i;
        dec_in      = '0;
        dec_in.sign = sign_i;
        dec_in.nx   = grd | stk;
        dec_in.rm   = rm_i;
        dec_in.man  = sig_i[MAN_W+GRS_W-1:GRS_W];
        dec_in.exp  = exp_i;
        case (rm_i)
            RM_RNE:  dec_in.up = grd & (stk | lsb);
            RM_RDN:  dec_in.up = sign_i & (grd | stk);
            RM_RUP:  dec_in.up = ~sign_i & (grd | stk);
            RM_RMM:  dec_in.up = grd;
            default: dec_in.up = 1'b0;
        endcase
    end

    function automatic res_t finish_round(input dec_t d);
        logic [MAN_W:0] r;
        logic [EXP_W:0] e;
        logic           to_inf;
        res_t           o;
        r      = {1'b0, d.man} + {{MAN_W{1'b0}}, d.up};
        e      = {1'b0, d.exp} + {{EXP_W{1'b0}}, r[MAN_W]};
        to_inf = (d.rm == RM_RNE) || (d.rm == RM_RMM) ||
                 (d.rm == RM_RUP && !d.sign) || (d.rm == RM_RDN && d.sign);
        o.sign = d.sign;
        o.nx   = d.nx;
        o.of   = 1'b0;
        // On carry the low MAN_W bits of r are already zero.
        o.sig  = r[MAN_W-1:0];
        o.exp  = e[EXP_W-1:0];
        if (e >= {1'b0, {EXP_W{1'b1}}}) begin
            o.of  = 1'b1;
            o.nx  = 1'b1;
            o.exp = to_inf ? {EXP_W{1'b1}} : {{(EXP_W-1){1'b1}}, 1'b0};
            o.sig = to_inf ? {MAN_W{1'b0}} : {MAN_W{1'b1}};
        end
        return o;
    endfunction

    logic v_out_q, v_out_d;
    res_t res_q, res_d;
    logic adv_out;
    logic src_v;
    res_t src_res;

    assign adv_out = !v_out_q || ready_i;

    generate
        if (STAGES == 2) begin : g_two
            logic v1_q, v1_d;
            dec_t d1_q, d1_d;

            assign ready_o = !v1_q || adv_out;
            assign src_v   = v1_q;
            assign src_res = finish_round(d1_q);

            always_comb begin
                v1_d = v1_q;
                d1_d = d1_q;
                if (ready_o) begin
                    v1_d = valid_i;
                    if (valid_i) d1_d = dec_in;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    v1_q <= 1'b0;
                    d1_q <= '0;
                end else begin
                    v1_q <= v1_d;
                    d1_q <= d1_d;
                end
            end
        end else begin : g_one
            assign ready_o = adv_out;
            assign src_v   = valid_i;
            assign src_res = finish_round(dec_in);
        end
    endgenerate

    always_comb begin
        v_out_d = v_out_q;
        res_d   = res_q;
        if (adv_out) begin
            v_out_d = src_v;
            if (src_v) res_d = src_res;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_out_q <= 1'b0;
            res_q   <= '0;
        end else begin
            v_out_q <= v_out_d;
            res_q   <= res_d;
        end
    end

    assign valid_o = v_out_q;
    assign sign_o  = res_q.sign;
    assign sig_o   = res_q.sig;
    assign exp_o   = res_q.exp;
    assign nx_o    = res_q.nx;
    assign of_o    = res_q.of;
endmodule

// File: tb/tb_fround_pipe.sv
// Bench for fround_pipe: two instances (single precision / 2 stages and a small
// 5-bit-exponent / 1 stage format), directed and random beats against a numeric model.
module tb_fround_pipe;
    localparam int A_EW = 8, A_MW = 23, A_GW = 8, A_ST = 2;
    localparam int B_EW = 5, B_MW = 10, B_GW = 3, B_ST = 1;

    typedef struct packed {
        logic        sign;
        logic [63:0] sig;
        logic        sticky;
        logic [15:0] exp;
        logic [2:0]  rm;
    } beat_t;

    typedef struct packed {
        logic        sign;
        logic [63:0] sig;
        logic [15:0] exp;
        logic        nx;
        logic        of;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, sign_in, sticky_in, ready_in;
    logic [2:0]  rm_in;
    logic [63:0] sig_in;
    logic [15:0] exp_in;
    int          cfg;
    int          EW, MW, GW, ST;
    string       tag;

    logic va_i, vb_i;
    assign va_i = valid_in && (cfg == 0);
    assign vb_i = valid_in && (cfg == 1);

    logic ready_a, valid_a, sign_a, nx_a, of_a;
    logic [A_MW-1:0] sig_a;
    logic [A_EW-1:0] exp_a;
    logic ready_b, valid_b, sign_b, nx_b, of_b;
    logic [B_MW-1:0] sig_b;
    logic [B_EW-1:0] exp_b;

    fround_pipe #(.EXP_W(A_EW), .MAN_W(A_MW), .GRS_W(A_GW), .STAGES(A_ST)) dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(va_i), .ready_o(ready_a),
        .sign_i(sign_in), .sig_i(sig_in[A_MW+A_GW:0]), .sticky_i(sticky_in),
        .exp_i(exp_in[A_EW-1:0]), .rm_i(rm_in), .valid_o(valid_a), .ready_i(ready_in),
        .sign_o(sign_a), .sig_o(sig_a), .exp_o(exp_a), .nx_o(nx_a), .of_o(of_a));

    fround_pipe #(.EXP_W(B_EW), .MAN_W(B_MW), .GRS_W(B_GW), .STAGES(B_ST)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(vb_i), .ready_o(ready_b),
        .sign_i(sign_in), .sig_i(sig_in[B_MW+B_GW:0]), .sticky_i(sticky_in),
        .exp_i(exp_in[B_EW-1:0]), .rm_i(rm_in), .valid_o(valid_b), .ready_i(ready_in),
        .sign_o(sign_b), .sig_o(sig_b), .exp_o(exp_b), .nx_o(nx_b), .of_o(of_b));

    logic        ready_o_m, valid_o_m;
    res_t        out_m;

    always_comb begin
        if (cfg == 0) begin
            ready_o_m = ready_a;
            valid_o_m = valid_a;
            out_m     = {sign_a, 64'(sig_a), 16'(exp_a), nx_a, of_a};
        end else begin
            ready_o_m = ready_b;
            valid_o_m = valid_b;
            out_m     = {sign_b, 64'(sig_b), 16'(exp_b), nx_b, of_b};
        end
    end

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    rdy_mode;
    beat_t stim_q[$];
    res_t  obs_q[$];
    int    dlv_cyc[$];
    int    stall_inflight;
    bit    timed_out;

    function automatic string fmt(input res_t r);
        return $sformatf("sign=%0b sig=%0h exp=%0h nx=%0b of=%0b", r.sign, r.sig, r.exp, r.nx, r.of);
    endfunction

    // Reference: treat the bits below the LSB as a fraction of one ulp and round numerically.
    function automatic res_t model(input beat_t b);
        longint unsigned half, rest, man, mones;
        int e, maxe;
        bit up, nx, inf;
        res_t r;
        half  = 64'd1 << (GW - 1);
        rest  = b.sig & ((64'd1 << GW) - 1);
        mones = (64'd1 << MW) - 1;
        man   = (b.sig >> GW) & mones;
        nx    = (rest != 0) || b.sticky;
        case (b.rm)
            3'd0:    up = (rest > half) || (rest == half && (b.sticky || man[0]));
            3'd2:    up = nx && b.sign;
            3'd3:    up = nx && !b.sign;
            3'd4:    up = (rest >= half);
            default: up = 1'b0;
        endcase
        man  = man + 64'(up);
        e    = int'(b.exp);
        if (man > mones) begin
            man = 0;
            e   = e + 1;
        end
        maxe = (1 << EW) - 1;
        r.of = 1'b0;
        if (e >= maxe) begin
            inf  = (b.rm == 0) || (b.rm == 4) || (b.rm == 3 && !b.sign) || (b.rm == 2 && b.sign);
            r.of = 1'b1;
            nx   = 1'b1;
            e    = inf ? maxe : maxe - 1;
            man  = inf ? 0 : mones;
        end
        r.sign = b.sign;
        r.sig  = man;
        r.exp  = 16'(e);
        r.nx   = nx;
        return r;
    endfunction

    function automatic beat_t mk_beat(input bit s, input longint unsigned sig, input bit st,
                                      input int e, input int rm);
        beat_t b;
        b.sign = s; b.sig = sig; b.sticky = st; b.exp = 16'(e); b.rm = 3'(rm);
        return b;
    endfunction

    function automatic res_t mk_res(input bit s, input longint unsigned sig, input int e,
                                    input bit nx, input bit of);
        res_t r;
        r.sign = s; r.sig = sig; r.exp = 16'(e); r.nx = nx; r.of = of;
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        longint unsigned s, gmask;
        int maxe;
        maxe  = (1 << EW) - 1;
        gmask = (64'd1 << GW) - 1;
        s = {$urandom(), $urandom()};
        s = (s & ((64'd1 << (MW + GW)) - 1)) | (64'd1 << (MW + GW));
        if ($urandom_range(0, 3) == 0) s = s | (((64'd1 << MW) - 1) << GW);
        if ($urandom_range(0, 3) == 0) s = (s & ~gmask) | (64'd1 << (GW - 1));
        b.sig    = s;
        b.sign   = 1'($urandom_range(0, 1));
        b.sticky = 1'($urandom_range(0, 1));
        b.rm     = 3'($urandom_range(0, 7));
        b.exp    = ($urandom_range(0, 3) == 0) ? 16'(maxe - $urandom_range(0, 1))
                                              : 16'($urandom_range(0, maxe));
        return b;
    endfunction

    task automatic drive(input beat_t b);
        sign_in   = b.sign;
        sig_in    = b.sig;
        sticky_in = b.sticky;
        exp_in    = b.exp;
        rm_in     = b.rm;
    endtask

    // Streams stim_q into the DUT under the current ready policy, records outputs.
    task automatic pump(input int n_out);
        int cyc, acc;
        cyc = 0;
        acc = 0;
        obs_q.delete();
        dlv_cyc.delete();
        stall_inflight = -1;
        while ((stim_q.size() != 0 || obs_q.size() < n_out) && cyc < 3000) begin
            @(negedge clk);
            case (rdy_mode)
                0:       ready_in = 1'b1;
                1:       ready_in = !(cyc >= 2 && cyc <= 5);
                default: ready_in = ($urandom_range(0, 3) != 0);
            endcase
            valid_in = (stim_q.size() != 0);
            if (valid_in) drive(stim_q[0]);
            #1;
            if (!ready_o_m && stall_inflight < 0) stall_inflight = acc - obs_q.size();
            if (valid_o_m && ready_in) begin
                obs_q.push_back(out_m);
                dlv_cyc.push_back(cyc);
            end
            if (valid_in && ready_o_m) begin
                void'(stim_q.pop_front());
                acc++;
            end
            cyc++;
        end
        timed_out = (stim_q.size() != 0 || obs_q.size() < n_out);
        valid_in  = 1'b0;
        stim_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (valid_o_m !== 1'b0) begin
            n_bad++; $display("FAIL %s reset_valid: got %0b want 0", tag, valid_o_m);
        end
        n_cmp++;
        if (out_m !== '0) begin
            n_bad++; $display("FAIL %s reset_outputs: got %s want all zero", tag, fmt(out_m));
        end
        n_cmp++;
        if (ready_o_m !== 1'b1) begin
            n_bad++; $display("FAIL %s reset_ready: got %0b want 1", tag, ready_o_m);
        end
    endtask

    task automatic test_directed();
        longint unsigned hid, ones, mones;
        int bias, maxe;
        res_t want[$];
        hid   = 64'd1 << (MW + GW);
        ones  = (64'd1 << (MW + GW + 1)) - 1;
        mones = (64'd1 << MW) - 1;
        bias  = (1 << (EW - 1)) - 1;
        maxe  = (1 << EW) - 1;
        stim_q.push_back(mk_beat(0, hid | (64'd1 << GW) | (64'd1 << (GW-1)), 0, bias, 0));
        want.push_back(mk_res(0, 2, bias, 1, 0));
        stim_q.push_back(mk_beat(0, hid | (64'd1 << (GW-1)), 0, bias, 0));
        want.push_back(mk_res(0, 0, bias, 1, 0));
        stim_q.push_back(mk_beat(0, ones, 0, bias, 0));
        want.push_back(mk_res(0, 0, bias + 1, 1, 0));
        stim_q.push_back(mk_beat(0, ones, 0, maxe - 1, 0));
        want.push_back(mk_res(0, 0, maxe, 1, 1));
        stim_q.push_back(mk_beat(0, ones, 0, maxe - 1, 1));
        want.push_back(mk_res(0, mones, maxe - 1, 1, 0));
        stim_q.push_back(mk_beat(1, ones, 0, maxe, 3));
        want.push_back(mk_res(1, mones, maxe - 1, 1, 1));
        stim_q.push_back(mk_beat(1, hid, 1, bias, 2));
        want.push_back(mk_res(1, 1, bias, 1, 0));
        stim_q.push_back(mk_beat(1, hid, 1, bias, 3));
        want.push_back(mk_res(1, 0, bias, 1, 0));
        stim_q.push_back(mk_beat(1, hid, 1, bias, 0));
        want.push_back(mk_res(1, 0, bias, 1, 0));
        stim_q.push_back(mk_beat(0, ones, 0, bias, 5));
        want.push_back(mk_res(0, mones, bias, 1, 0));
        stim_q.push_back(mk_beat(0, hid | (64'd5 << GW), 0, bias, 3));
        want.push_back(mk_res(0, 5, bias, 0, 0));
        stim_q.push_back(mk_beat(0, hid | (64'd1 << (GW-1)), 0, bias, 4));
        want.push_back(mk_res(0, 1, bias, 1, 0));
        stim_q.push_back(mk_beat(0, hid, 0, maxe, 2));
        want.push_back(mk_res(0, mones, maxe - 1, 1, 1));
        stim_q.push_back(mk_beat(0, hid, 0, maxe, 4));
        want.push_back(mk_res(0, 0, maxe, 1, 1));
        rdy_mode = 0;
        pump(want.size());
        if (timed_out) begin
            n_cmp++; n_bad++;
            $display("FAIL %s directed_timeout: got %0d outputs want %0d", tag, obs_q.size(), want.size());
        end
        for (int i = 0; i < obs_q.size() && i < want.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== want[i]) begin
                n_bad++;
                $display("FAIL %s directed[%0d]: got %s want %s", tag, i, fmt(obs_q[i]), fmt(want[i]));
            end
        end
    endtask

    task automatic test_latency();
        beat_t b;
        res_t  want;
        int    k;
        b    = rand_beat();
        want = model(b);
        @(negedge clk);
        ready_in = 1'b1;
        valid_in = 1'b1;
        drive(b);
        #1;
        n_cmp++;
        if (ready_o_m !== 1'b1) begin
            n_bad++; $display("FAIL %s latency_accept: got ready %0b want 1", tag, ready_o_m);
        end
        k = 0;
        do begin
            @(negedge clk);
            valid_in = 1'b0;
            k++;
            #1;
        end while (!valid_o_m && k < 20);
        n_cmp++;
        if (k != ST) begin
            n_bad++; $display("FAIL %s latency: got %0d cycles want %0d", tag, k, ST);
        end
        n_cmp++;
        if (out_m !== want) begin
            n_bad++; $display("FAIL %s latency_value: got %s want %s", tag, fmt(out_m), fmt(want));
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        res_t want[$];
        int   first_post, gaps;
        for (int i = 0; i < 6; i++) begin
            beat_t b;
            b = rand_beat();
            stim_q.push_back(b);
            want.push_back(model(b));
        end
        rdy_mode = 1;
        pump(6);
        if (timed_out) begin
            n_cmp++; n_bad++;
            $display("FAIL %s bp_timeout: got %0d outputs want 6", tag, obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 6; i++) begin
            n_cmp++;
            if (obs_q[i] !== want[i]) begin
                n_bad++;
                $display("FAIL %s bp[%0d]: got %s want %s", tag, i, fmt(obs_q[i]), fmt(want[i]));
            end
        end
        n_cmp++;
        if (stall_inflight != ST) begin
            n_bad++; $display("FAIL %s bp_held: got %0d held when ready_o fell want %0d", tag, stall_inflight, ST);
        end
        first_post = -1;
        gaps = 0;
        for (int i = 0; i < dlv_cyc.size(); i++) begin
            if (dlv_cyc[i] >= 6 && first_post < 0) first_post = dlv_cyc[i];
            if (i > 0 && dlv_cyc[i-1] >= 6 && dlv_cyc[i] != dlv_cyc[i-1] + 1) gaps++;
        end
        n_cmp++;
        if (first_post != 6 || gaps != 0) begin
            n_bad++;
            $display("FAIL %s bp_throughput: got first=%0d gaps=%0d want first=6 gaps=0", tag, first_post, gaps);
        end
    endtask

    task automatic test_random();
        res_t want[$];
        for (int i = 0; i < 150; i++) begin
            beat_t b;
            b = rand_beat();
            stim_q.push_back(b);
            want.push_back(model(b));
        end
        rdy_mode = 2;
        pump(150);
        if (timed_out) begin
            n_cmp++; n_bad++;
            $display("FAIL %s random_timeout: got %0d outputs want 150", tag, obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < want.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== want[i]) begin
                n_bad++;
                $display("FAIL %s random[%0d]: got %s want %s", tag, i, fmt(obs_q[i]), fmt(want[i]));
            end
        end
    endtask

    task automatic test_reset_mid();
        res_t want[$];
        @(negedge clk);
        ready_in = 1'b0;
        valid_in = 1'b1;
        drive(rand_beat());
        @(negedge clk);
        drive(rand_beat());
        @(negedge clk);
        #1;
        n_cmp++;
        if (valid_o_m !== 1'b1) begin
            n_bad++; $display("FAIL %s mid_prefill: got valid_o %0b want 1", tag, valid_o_m);
        end
        valid_in = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (valid_o_m !== 1'b0) begin
            n_bad++; $display("FAIL %s mid_reset_valid: got %0b want 0", tag, valid_o_m);
        end
        n_cmp++;
        if (out_m !== '0) begin
            n_bad++; $display("FAIL %s mid_reset_outputs: got %s want all zero", tag, fmt(out_m));
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            beat_t b;
            b = rand_beat();
            stim_q.push_back(b);
            want.push_back(model(b));
        end
        rdy_mode = 2;
        pump(10);
        if (timed_out) begin
            n_cmp++; n_bad++;
            $display("FAIL %s mid_timeout: got %0d outputs want 10", tag, obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < want.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== want[i]) begin
                n_bad++;
                $display("FAIL %s mid_post[%0d]: got %s want %s", tag, i, fmt(obs_q[i]), fmt(want[i]));
            end
        end
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
        sign_in = 1'b0; sticky_in = 1'b0; rm_in = '0; sig_in = '0; exp_in = '0;
        cfg = 0; rdy_mode = 0;
        for (int c = 0; c < 2; c++) begin
            cfg = c;
            if (c == 0) begin
                EW = A_EW; MW = A_MW; GW = A_GW; ST = A_ST; tag = "fmtA";
            end else begin
                EW = B_EW; MW = B_MW; GW = B_GW; ST = B_ST; tag = "fmtB";
            end
            test_reset();
            test_directed();
            test_latency();
            test_backpressure();
            test_random();
            test_reset_mid();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fround_pipe.md
Name: fround_pipe

Overview:
- Parametrised, pipelined successor to the FPU's combinational significand rounder.
- Takes a normalised significand with guard/round/sticky field, a biased exponent, a sign and a rounding mode. Produces the rounded mantissa and exponent plus inexact and overflow flags.
- Supports any IEEE-style format through parameters: half, single or double precision.
- Sits between the FPU normalisation stage and result packing, with a valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width, hidden bit excluded.
- GRS_W, 8, number of extra bits below the mantissa LSB; must be at least 2.
- STAGES, 2, pipeline depth; legal values are 1 or 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  input beat valid
- ready_o  out  1  block can accept an input this cycle
- sign_i  in  1  sign of the value
- sig_i  in  MAN_W+GRS_W+1  significand; MSB is the hidden 1
- sticky_i  in  1  OR of bits already shifted out upstream
- exp_i  in  EXP_W  biased exponent
- rm_i  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts the output
- sign_o  out  1  sign, passed through
- sig_o  out  MAN_W  rounded mantissa, hidden bit excluded
- exp_o  out  EXP_W  result exponent
- nx_o  out  1  inexact flag
- of_o  out  1  overflow flag

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is synchronous and active-high.
- Reset values: valid_o=0, sign_o=0, sig_o=0, exp_o=0, nx_o=0, of_o=0. All internal stage valids clear. ready_o=1 in the cycle after reset deasserts.
- Handshake:
  - An input transfers when valid_i && ready_o.
  - An output transfers when valid_o && ready_i.
  - Stage k loads when it is empty, or when its content moves forward that same cycle.
  - ready_o = !v1 || (stage 1 advances this cycle), where v1 is stage 1's valid.
  - Full throughput is one beat per cycle. Bubbles collapse. Order is preserved; nothing is dropped or duplicated.
  - Outputs hold stable while valid_o && !ready_i.
- Latency: STAGES cycles from input transfer to valid_o when there is no backpressure.
- Field decode:
  - L = sig_i[GRS_W], the mantissa LSB.
  - G = sig_i[GRS_W-1].
  - S = |sig_i[GRS_W-2:0] | sticky_i.
  - nx = G | S.
- Round-up decision (stage 1):
  - RNE: G & (S | L).
  - RTZ: 0.
  - RDN: sign & nx.
  - RUP: !sign & nx.
  - RMM: G.
  - Modes 101/110/111 are reserved: behave as RTZ, and nx is still reported.
- Increment (last stage):
  - r = {1'b0, sig_i[MAN_W+GRS_W-1:GRS_W]} + up, width MAN_W+1.
  - If r[MAN_W] is set (carry): sig = 0, exp = exp_i+1.
  - Otherwise: sig = r[MAN_W-1:0], exp = exp_i.
- Overflow, when the resulting exp equals all-ones (this includes exp_i already all-ones):
  - of_o=1 and nx_o=1.
  - Infinity (exp all-ones, sig 0) for: RNE, RMM, RUP with positive sign, RDN with negative sign.
  - Max finite (exp all-ones minus 1, sig all-ones) for: RTZ, reserved modes, RUP with negative sign, RDN with positive sign.
- STAGES=1: decision and increment both happen in one registered stage.
- STAGES=2: stage 1 registers the up, nx, sign, mantissa field, exponent and mode. Stage 2 registers the final result.
- Simultaneous events: input accept and output drain in the same cycle with the pipeline full is legal and keeps full throughput.
- Reset mid-operation: all in-flight beats are discarded. valid_o=0 in the cycle after rst_i is sampled high. No partial beat appears after reset.
- Width rules: exponent arithmetic is EXP_W+1 bits internally so the increment never wraps silently.

Test Plan:
- RNE tie-to-even (defaults): sig_i=32'h8000_0180, exp_i=8'h7F, sticky_i=0 -> sig_o=23'h000002, exp_o=8'h7F, nx_o=1, of_o=0. The same case with sig_i=32'h8000_0080 -> sig_o=0, nx_o=1.
- Carry renormalise: sig_i=32'hFFFF_FFFF, exp_i=8'h7F, RNE -> sig_o=0, exp_o=8'h80, nx_o=1.
- Overflow:
  - sig_i=32'hFFFF_FFFF, exp_i=8'hFE, RNE -> exp_o=8'hFF, sig_o=0, of_o=1, nx_o=1.
  - Same input with RTZ -> exp_o=8'hFE, sig_o=23'h7FFFFF, of_o=0, nx_o=1.
  - exp_i=8'hFF, RUP, sign_i=1 -> exp_o=8'hFE, sig_o=23'h7FFFFF, of_o=1.
- Sticky-only directed round: sig_i=32'h8000_0000, sticky_i=1, sign_i=1:
  - RDN -> sig_o=23'h000001, nx_o=1.
  - RUP -> sig_o=0, nx_o=1.
  - RNE -> sig_o=0, nx_o=1.
- Backpressure: issue 6 back-to-back beats while holding ready_i=0 for cycles 2-5.
  - ready_o falls once STAGES beats are held.
  - All 6 outputs arrive in order with correct values and none lost.
  - Once ready_i returns, throughput returns to one beat per cycle.
- Reset mid-stream: assert rst_i with 2 beats in flight -> valid_o=0 next cycle, all outputs 0. Later outputs come only from post-reset inputs. Repeat the whole suite with EXP_W=5, MAN_W=10, STAGES=1.
